regfile_write_ctrl: RTL

Write-port controller for the 32-entry register file. It owns the file's single write port (`rd`, `writeData`, `regWrite`). After reset it sequences a zero-clear of every entry. It then arbitrates round-robin between two writeback requesters, the ALU path and the load/memory path, using valid/ready handshakes. Writes targeting x0 are suppressed, and the block keeps a saturating count of cycles in which a requester was stalled.

---
 rtl/regfile_write_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: owns the register file's single write port.
// After reset it clears every entry, then arbitrates round-robin between
// the ALU and load writeback paths, suppresses writes to x0 and counts
// stalled-requester cycles with saturation.
module regfile_write_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int STALL_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_writeData,
  output logic                  rf_regWrite,
  output logic                  init_done,
  output logic [STALL_W-1:0]    stall_count
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  last_mem, last_mem_nxt;
  logic [ADDR_WIDTH-1:0] rd_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  we_nxt;
  logic [STALL_W-1:0]    stall_nxt;

  assign init_done = (state == RUN);

  // Next-state, grant and write-port computation; last_mem=1 means MEM won last.
  always_comb begin
    state_nxt    = state;
    clr_cnt_nxt  = clr_cnt;
    last_mem_nxt = last_mem;
    rd_nxt       = rf_rd;
    data_nxt     = rf_writeData;
    we_nxt       = 1'b0;
    stall_nxt    = stall_count;
    alu_ready    = 1'b0;
    mem_ready    = 1'b0;
    case (state)
      INIT: begin
        rd_nxt      = clr_cnt;
        data_nxt    = '0;
        we_nxt      = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (alu_valid && (!mem_valid || last_mem)) begin
          alu_ready = 1'b1;
        end else if (mem_valid) begin
          mem_ready = 1'b1;
        end
        if (alu_ready) begin
          rd_nxt       = alu_rd;
          data_nxt     = alu_data;
          we_nxt       = (alu_rd != '0);
          last_mem_nxt = 1'b0;
        end else if (mem_ready) begin
          rd_nxt       = mem_rd;
          data_nxt     = mem_data;
          we_nxt       = (mem_rd != '0);
          last_mem_nxt = 1'b1;
        end
        if (alu_valid && mem_valid && (stall_count != {STALL_W{1'b1}})) begin
          stall_nxt = stall_count + 1'b1;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Control state: FSM, clear counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      clr_cnt  <= '0;
      last_mem <= 1'b1;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      last_mem <= last_mem_nxt;
    end
  end

  // Registered write port and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_rd        <= '0;
      rf_writeData <= '0;
      rf_regWrite  <= 1'b0;
      stall_count  <= '0;
    end else begin
      rf_rd        <= rd_nxt;
      rf_writeData <= data_nxt;
      rf_regWrite  <= we_nxt;
      stall_count  <= stall_nxt;
    end
  end

endmodule
